// File: rtl/program_loader.sv
// Boot-time program loader: assembles a UART byte stream (little-endian
// word count, then little-endian 32-bit words) into instruction-memory
// writes, then returns a one-byte acknowledge and releases the core.
module program_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_LEN     = 3'd0;
  localparam logic [2:0] S_DATA    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERR_ACK = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  // Word index carries one extra bit so a full-capacity load is legal.
  localparam int          IDX_W = ADDR_WIDTH + 1;
  localparam logic [32:0] MAX_N = 33'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           shift_q, shift_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  accept;
  logic                  last_wr;
  logic [31:0]           assembled;

  // The length and each data word share one shift register; the newest byte
  // enters at the top so the first byte ends up in bits 7:0.
  assign assembled = {rx_data, shift_q[31:8]};

  // Write pulse of the final word: stall input for exactly that cycle.
  assign last_wr  = we_q && ((idx_q + IDX_W'(1)) == len_q);

  assign rx_ready = (state_q == S_LEN) || ((state_q == S_DATA) && !last_wr);
  assign accept   = rx_valid && rx_ready;

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  assign tx_valid = (state_q == S_ACK) || (state_q == S_ERR_ACK);
  assign tx_data  = (state_q == S_ACK)     ? 8'hAA :
                    (state_q == S_ERR_ACK) ? 8'hEE : 8'h00;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);

  // Next-state, byte assembly and write-strobe generation.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (accept) begin
      shift_d    = assembled;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      S_LEN: begin
        if (accept && (byte_cnt_q == 2'd3)) begin
          if ({1'b0, assembled} > MAX_N) begin
            state_d = S_ERR_ACK;
          end else if (assembled == 32'd0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_DATA;
            len_d   = assembled[IDX_W-1:0];
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (we_q) begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (last_wr) begin
          state_d = S_ACK;
        end
        if (accept && (byte_cnt_q == 2'd3)) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_WIDTH-1:0];
          wdata_d = assembled;
        end
      end
      S_ACK: begin
        if (tx_ready) begin
          state_d = S_DONE;
        end
      end
      S_ERR_ACK: begin
        if (tx_ready) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN;
    endcase
  end

  // All state clears immediately on reset; a partial word is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LEN;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
      len_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (ADDR_WIDTH=4 so capacity limits are
// reachable): loads, empty load, oversize rejection, full-capacity load,
// gapped input with delayed acknowledge, and reset in the middle of a load.
module tb_program_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log captured mid-cycle.
  logic [AW-1:0] wr_addr [0:63];
  logic [31:0]   wr_data [0:63];
  logic          wr_rdy  [0:63];
  int            wr_cyc  [0:63];
  int            wn = 0;
  int            wide = 0;
  logic          prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wn < 64) begin
        wr_addr[wn] <= imem_addr;
        wr_data[wn] <= imem_wdata;
        wr_rdy[wn]  <= rx_ready;
        wr_cyc[wn]  <= cyc;
      end
      wn <= wn + 1;
      if (prev_we) wide <= wide + 1;
    end
    prev_we <= imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " ctl"}, 32'({rx_ready, imem_we, tx_valid, done, err}), 32'b10000);
    check({tag, " addr"}, 32'(imem_addr), 32'd0);
    check({tag, " wdata"}, imem_wdata, 32'd0);
    check({tag, " tx_data"}, 32'(tx_data), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_idle(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    g = 0;
    @(negedge clk);
    while (!rx_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gapped);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], gapped ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic do_ack(input string tag, input logic [7:0] exp, input int hold,
                        input logic is_err, output int tcyc);
    int g;
    g = 0;
    @(negedge clk);
    while (!tx_valid && g < 200) begin @(negedge clk); g++; end
    tcyc = cyc;
    check({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
    check({tag, " tx_data"}, 32'(tx_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " tx_hold"}, 32'({tx_valid, tx_data, done, err}), 32'({1'b1, exp, 2'b00}));
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check({tag, " pre_handshake"}, 32'({done, err, tx_valid}), 32'b001);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check({tag, " post_handshake"}, 32'({done, err, tx_valid}), 32'({~is_err, is_err, 1'b0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tcyc, lcyc, c0;

    // Reset values while reset is held from time zero.
    #12;
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // N=2 streamed one byte per cycle.
    base = wn;
    c0 = cyc;
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h0000_0513, 1'b0);
    send_word(32'h0010_0593, 1'b0);
    lcyc = cyc;
    check("t1 stream_cycles", 32'(lcyc - c0), 32'd12);
    do_ack("t1", 8'hAA, 0, 1'b0, tcyc);
    check("t1 nwrites", 32'(wn - base), 32'd2);
    check("t1 addr0", 32'(wr_addr[base]), 32'd0);
    check("t1 data0", wr_data[base], 32'h0000_0513);
    check("t1 addr1", 32'(wr_addr[base+1]), 32'd1);
    check("t1 data1", wr_data[base+1], 32'h0010_0593);
    check("t1 rdy_nonlast", 32'(wr_rdy[base]), 32'd1);
    check("t1 rdy_last", 32'(wr_rdy[base+1]), 32'd0);
    check("t1 last_wr_cycle", 32'(wr_cyc[base+1]), 32'(lcyc));
    check("t1 tx_cycle", 32'(tcyc), 32'(lcyc + 1));
    // Bytes after DONE are not accepted.
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1 done_ignore", 32'({rx_ready, done}), 32'b01);
    end
    rx_valid = 1'b0;
    check("t1 no_extra_writes", 32'(wn - base), 32'd2);

    // N=0, with a reset landing in the middle of the acknowledge.
    do_reset("t2 reset");
    send_word(32'h0000_0000, 1'b0);
    @(negedge clk);
    check("t2 ack_before_reset", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hAA}));
    rst_n = 1'b0;
    #1;
    check("t2 async_reset_ack", 32'({tx_valid, rx_ready}), 32'b01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = wn;
    send_word(32'h0000_0000, 1'b0);
    lcyc = cyc;
    do_ack("t2", 8'hAA, 0, 1'b0, tcyc);
    check("t2 tx_cycle", 32'(tcyc), 32'(lcyc));
    check("t2 nwrites", 32'(wn - base), 32'd0);

    // N=17 exceeds 16-word capacity.
    do_reset("t3 reset");
    base = wn;
    send_word(32'h0000_0011, 1'b0);
    lcyc = cyc;
    do_ack("t3", 8'hEE, 0, 1'b1, tcyc);
    check("t3 tx_cycle", 32'(tcyc), 32'(lcyc));
    check("t3 nwrites", 32'(wn - base), 32'd0);
    @(negedge clk);
    check("t3 err_sticky", 32'({err, done, rx_ready}), 32'b100);

    // Oversize only in the top length byte.
    do_reset("t3b reset");
    base = wn;
    send_word(32'h0100_0001, 1'b0);
    do_ack("t3b", 8'hEE, 0, 1'b1, tcyc);
    check("t3b nwrites", 32'(wn - base), 32'd0);

    // N=16: full capacity, addresses 0..15 with no wrap.
    do_reset("t4 reset");
    base = wn;
    send_word(32'h0000_0010, 1'b0);
    for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 | 32'(i), 1'b0);
    do_ack("t4", 8'hAA, 0, 1'b0, tcyc);
    check("t4 nwrites", 32'(wn - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t4 addr", 32'(wr_addr[base+i]), 32'(i));
      check("t4 data", wr_data[base+i], 32'hC0DE_0000 | 32'(i));
    end
    check("t4 rdy_last", 32'(wr_rdy[base+15]), 32'd0);

    // Gapped input and a delayed acknowledge.
    do_reset("t5 reset");
    base = wn;
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h0000_0513, 1'b1);
    send_word(32'h0010_0593, 1'b1);
    do_ack("t5", 8'hAA, 5, 1'b0, tcyc);
    check("t5 nwrites", 32'(wn - base), 32'd2);
    check("t5 addr0", 32'(wr_addr[base]), 32'd0);
    check("t5 data0", wr_data[base], 32'h0000_0513);
    check("t5 addr1", 32'(wr_addr[base+1]), 32'd1);
    check("t5 data1", wr_data[base+1], 32'h0010_0593);

    // Reset after two bytes of word 1, then a fresh N=1 load.
    do_reset("t6 reset");
    base = wn;
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h0000_0513, 1'b0);
    send_byte(8'h93, 0);
    send_byte(8'h05, 0);
    rst_n = 1'b0;
    #1;
    chk_idle("t6 mid_word_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6 prereset_writes", 32'(wn - base), 32'd1);
    base = wn;
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    do_ack("t6", 8'hAA, 0, 1'b0, tcyc);
    check("t6 nwrites", 32'(wn - base), 32'd1);
    check("t6 addr0", 32'(wr_addr[base]), 32'd0);
    check("t6 data0", wr_data[base], 32'hDEAD_BEEF);

    check("we_single_cycle", 32'(wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that fills instruction memory, the producer side of the instruction stream the core's decode/control path consumes. It accepts a byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them to consecutive instruction-memory word addresses. It then returns a one-byte acknowledge on the UART transmit path and asserts `done` to release the core.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  receive byte valid.
- `rx_data`  in  8  receive byte.
- `rx_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `tx_valid`  out  1  acknowledge byte valid.
- `tx_data`  out  8  acknowledge byte.
- `tx_ready`  in  1  transmitter accepts byte.
- `done`  out  1  program loaded; sticky until reset.
- `err`  out  1  length rejected; sticky until reset.

## Operation
- A byte is accepted on a rising edge where `rx_valid & rx_ready`. The sender may hold `rx_valid` high and stream bytes every cycle.
- Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte is bits 7:0).
- States: LEN, DATA, ACK, DONE, ERR_ACK, ERR. Reset state is LEN.
- LEN: `rx_ready`=1. Collect 4 bytes into a 32-bit N using a 2-bit byte counter. When the 4th byte is accepted:
  - N > 2**ADDR_WIDTH: go to ERR_ACK.
  - N == 0: go to ACK.
  - Otherwise: go to DATA with word index 0.
- DATA: `rx_ready`=1. Shift bytes into the assembly register. When the 4th byte of a word is accepted, the registered outputs `imem_we`/`imem_addr`/`imem_wdata` present that word in the next cycle. The word index increments at that write cycle's edge.
  - While the write pulse for the last word (index N-1) is high, `rx_ready`=0. The next state is ACK.
  - Bytes are never dropped while a non-last write is in flight.
- ACK: `rx_ready`=0, `tx_valid`=1, `tx_data`=8'hAA. Hold until `tx_ready`, then go to DONE.
- DONE: `done`=1, `rx_ready`=0. Further rx bytes are ignored (not accepted). Leave only via reset.
- ERR_ACK: as ACK but `tx_data`=8'hEE, then go to ERR.
- ERR: `err`=1, `rx_ready`=0. Leave only via reset.
- Word index width is ADDR_WIDTH+1 so that N = 2**ADDR_WIDTH is allowed. `imem_addr` is the low ADDR_WIDTH bits and never wraps within a load.
- Reset asserted at any time, including mid-word or mid-ACK: state, counters, assembly register and all outputs clear immediately. A partial word is discarded and never written.

## Timing
- Reset values: `rx_ready`=1 (state LEN), `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `tx_valid`=0, `tx_data`=0, `done`=0, `err`=0.
- Word write latency: 4th byte accepted at edge k, `imem_we`=1 during cycle k..k+1, written at edge k+1. `imem_we` is exactly one cycle wide.
- Last word: `tx_valid` is first high in the cycle after the last `imem_we` pulse.
- N == 0 or N too large: `tx_valid` is high in the cycle after the 4th length byte is accepted.
- `tx_valid`/`tx_data` are stable until the handshake. `done` or `err` rises in the cycle after the `tx_valid & tx_ready` edge.
- Back-to-back bytes, one per cycle: N words take 4+4N accept cycles. The loader adds one stall cycle, after the final word.

## Test plan
- Reset, then N=2 streamed every cycle: bytes 02 00 00 00 13 05 00 00 93 05 10 00.
  - Expect writes addr0=32'h00000513 and addr1=32'h00100593, one cycle each.
  - Then `tx_data`=8'hAA, then `done`=1.
- N=0: bytes 00 00 00 00 → no `imem_we`, ACK 8'hAA, `done`=1.
- ADDR_WIDTH=4, N=17 → ERR_ACK 8'hEE, `err`=1, no writes.
- ADDR_WIDTH=4, N=16 → 16 writes to addr 0..15 (no wrap), then ACK.
- Gapped `rx_valid` (random idle cycles) and `tx_ready` held low 5 cycles → identical writes. `tx_valid` is held through the 5 cycles. `done` rises the cycle after `tx_ready` goes high.
- Reset pulsed after byte 2 of word 1, then a full N=1 reload → no write from the partial word; addr0 gets the reload word.
